// File: rtl/fetch_staged.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills the IF/DEC register.
// Branches resolved in decode redirect the PC after a single architectural delay slot.
module fetch_staged #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h8B1F_03FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BrTaken,
  input  logic        UncondBr,
  input  logic        pc_rd,
  input  logic [63:0] Reg2,
  input  logic        stall,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [63:0] PCPlusFour
);

  logic [63:0] pc_r;
  logic [31:0] instr_r;
  logic [63:0] pc_plus4_r;
  logic [63:0] pc_dec_r;

  logic [63:0] off_x4_s;
  logic [63:0] target_s;
  logic [63:0] pc_inc_s;
  logic [63:0] next_pc_s;

  // Branch offset (already scaled by 4) taken from the word sitting in decode
  always_comb begin
    off_x4_s = 64'h0;
    if (UncondBr) begin
      off_x4_s = {{36{instr_r[25]}}, instr_r[25:0], 2'b00};
    end else begin
      off_x4_s = {{43{instr_r[23]}}, instr_r[23:5], 2'b00};
    end
  end

  assign target_s = pc_dec_r + off_x4_s;
  assign pc_inc_s = pc_r + 64'd4;

  // Next-PC priority: stall, register-indirect, immediate branch, sequential
  always_comb begin
    next_pc_s = pc_inc_s;
    if (stall) begin
      next_pc_s = pc_r;
    end else if (pc_rd) begin
      next_pc_s = Reg2;
    end else if (BrTaken) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = pc_inc_s;
    end
  end

  // PC and IF/DEC registers; the fetched word is never squashed (delay slot)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= RESET_PC;
      pc_dec_r   <= RESET_PC - 64'd4;
    end else if (!stall) begin
      pc_r       <= next_pc_s;
      instr_r    <= imem_data;
      pc_plus4_r <= pc_inc_s;
      pc_dec_r   <= pc_r;
    end else begin
      pc_r       <= pc_r;
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      pc_dec_r   <= pc_dec_r;
    end
  end

  assign imem_addr   = pc_r;
  assign instruction = instr_r;
  assign PCPlusFour  = pc_plus4_r;

endmodule

// File: tb/tb_fetch_staged.sv
// Bench for fetch_staged: directed branch/stall/reset scenarios plus randomized traffic,
// all checked every cycle against a fetch-stream model of the stage.
module tb_fetch_staged;

  localparam logic [31:0] NOP = 32'h8B1F_03FF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        BrTaken = 1'b0;
  logic        UncondBr = 1'b0;
  logic        pc_rd = 1'b0;
  logic [63:0] Reg2 = 64'h0;
  logic        stall = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [63:0] PCPlusFour;

  // second instance parked at the top of the address space, free running
  logic        w_zero = 1'b0;
  logic [63:0] w_reg2 = 64'h0;
  logic [63:0] w_imem_addr;
  logic [31:0] w_imem_data;
  logic [31:0] w_instruction;
  logic [63:0] w_ppf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // memory image: two branch words, small addresses return their own address, else a hash
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h10:  return 32'h54FF_FFC0;  // B.cond imm19 = -2
      64'h20:  return 32'h9400_0100;  // BL imm26 = 0x100
      default: return (a < 64'h1_0000) ? a[31:0] : ((a[31:0] * 32'h9E37_79B1) ^ a[63:32]);
    endcase
  endfunction

  assign imem_data   = mem_word(imem_addr);
  assign w_imem_data = w_imem_addr[31:0];

  fetch_staged #(.RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .BrTaken(BrTaken), .UncondBr(UncondBr), .pc_rd(pc_rd),
    .Reg2(Reg2), .stall(stall), .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .PCPlusFour(PCPlusFour)
  );

  fetch_staged #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .reset(reset), .BrTaken(w_zero), .UncondBr(w_zero), .pc_rd(w_zero),
    .Reg2(w_reg2), .stall(w_zero), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .instruction(w_instruction), .PCPlusFour(w_ppf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: fetch address, decode word and its address ----------------
  logic [63:0] m_pc;
  logic [63:0] m_daddr;
  logic [31:0] m_instr;

  function automatic logic [63:0] branch_dest(input logic [63:0] a, input logic [31:0] w,
                                              input logic u);
    longint      off;
    logic [63:0] offu;
    if (u) off = $signed(w[25:0]);
    else   off = $signed(w[23:5]);
    offu = off;
    return a + offu * 64'd4;
  endfunction

  function automatic logic [63:0] model_next();
    if (pc_rd)   return Reg2;
    if (BrTaken) return branch_dest(m_daddr, m_instr, UncondBr);
    return m_pc + 64'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc    <= 64'h0;
      m_instr <= NOP;
      m_daddr <= 64'h0 - 64'd4;
    end else if (!stall) begin
      m_pc    <= model_next();
      m_instr <= mem_word(m_pc);
      m_daddr <= m_pc;
    end
  end

  // compare process: outputs are meaningful every cycle, including reset
  always @(negedge clk) begin
    check("imem_addr", imem_addr, m_pc);
    check("instruction", {32'h0, instruction}, {32'h0, m_instr});
    check("PCPlusFour", PCPlusFour, m_daddr + 64'd4);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_daddr(input logic [63:0] a);
    for (int k = 0; k < 50; k++) begin
      if (m_daddr == a) return;
      step();
    end
    check("wait_decode_addr", m_daddr, a);
  endtask

  initial begin
    // reset held two cycles
    step();
    step();
    check("rst_instr", {32'h0, instruction}, {32'h0, NOP});
    check("rst_ppf", PCPlusFour, 64'h0);
    check("rst_addr", imem_addr, 64'h0);
    check("wrap_rst_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_rst_ppf", w_ppf, 64'hFFFF_FFFF_FFFF_FFFC);
    reset = 1'b0;
    step();
    check("seq1_addr", imem_addr, 64'h4);
    check("seq1_instr", {32'h0, instruction}, 64'h0);
    check("seq1_ppf", PCPlusFour, 64'h4);
    check("wrap_addr", w_imem_addr, 64'h0);
    check("wrap_instr", {32'h0, w_instruction}, 64'hFFFF_FFFC);
    check("wrap_ppf", w_ppf, 64'h0);
    step();
    check("seq2_addr", imem_addr, 64'h8);
    check("seq2_instr", {32'h0, instruction}, 64'h4);

    // conditional branch at 0x10, imm19 = -2
    wait_daddr(64'h10);
    check("bcond_slot_addr", imem_addr, 64'h14);
    BrTaken = 1'b1; UncondBr = 1'b0;
    step();
    BrTaken = 1'b0;
    check("bcond_target", imem_addr, 64'h8);
    check("bcond_slot_instr", {32'h0, instruction}, 64'h14);

    // BL at 0x20, imm26 = 0x100
    wait_daddr(64'h20);
    check("bl_ppf", PCPlusFour, 64'h24);
    check("bl_instr", {32'h0, instruction}, 64'h9400_0100);
    BrTaken = 1'b1; UncondBr = 1'b1;
    step();
    check("bl_target", imem_addr, 64'h420);
    check("bl_slot_instr", {32'h0, instruction}, 64'h24);

    // BR overrides the immediate target of the word in decode (0x24)
    pc_rd = 1'b1; BrTaken = 1'b1; UncondBr = 1'b0; Reg2 = 64'h2000;
    step();
    pc_rd = 1'b0; BrTaken = 1'b0;
    check("br_target", imem_addr, 64'h2000);
    check("br_slot_instr", {32'h0, instruction}, 64'h420);
    step();

    // stall three cycles with a branch pending
    stall = 1'b1; BrTaken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr", imem_addr, 64'h2004);
      check("stall_instr", {32'h0, instruction}, 64'h2000);
      check("stall_ppf", PCPlusFour, 64'h2004);
    end
    stall = 1'b0;
    step();
    BrTaken = 1'b0;
    check("post_stall_target", imem_addr, 64'h2400);
    check("post_stall_instr", {32'h0, instruction}, 64'h2004);

    // async reset asserted mid-cycle
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_addr", imem_addr, 64'h0);
    check("async_instr", {32'h0, instruction}, {32'h0, NOP});
    check("async_ppf", PCPlusFour, 64'h0);
    check("async_wrap_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      stall    = ($urandom_range(0, 9) == 0);
      BrTaken  = ($urandom_range(0, 4) == 0);
      UncondBr = 1'($urandom_range(0, 1));
      pc_rd    = ($urandom_range(0, 19) == 0);
      Reg2     = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) Reg2[63:16] = 48'h0;
      if ($urandom_range(0, 79) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
